// File: rtl/cooling_fan_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// cooling_fan_ramp_ctrl
//
// Purpose:
//    Moves the applied fan level toward the requested fan_mode one level at a
//    time, waiting STEP_DWELL cycles before each step. A fault jumps straight
//    to full speed. A free-running 7-phase PWM drives the fan pin. All outputs
//    are registered.
//
// Ports:
//    clk        in   system clock (1 Hz tick in the ride system)
//    rst        in   asynchronous, active-high reset
//    enable     in   ride active; when low the target is forced to 0
//    fan_mode   in   [2:0] requested fan level
//    fault      in   sensor / over-pressure fault, forces level 7
//    fan_level  out  [2:0] currently applied fan level
//    pwm_out    out  fan PWM drive
//    settled    out  level equals the target and no ramp is in progress
//    ramping    out  a ramp (or kick) is in progress
//
// Build option:
//    FAN_KICKSTART_EN - when defined, a start from stop first runs the fan at
//    level 7 for KICK_CYCLES cycles, then continues the ramp from level 1.
// -----------------------------------------------------------------------------
module cooling_fan_ramp_ctrl #(
   parameter int STEP_DWELL  = 4,
   parameter int KICK_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [2:0] fan_mode,
   input  logic       fault,
   output logic [2:0] fan_level,
   output logic       pwm_out,
   output logic       settled,
   output logic       ramping
);

   // Both counts share the 8-bit dwell counter, so both must fit in 1..255.
   if (STEP_DWELL < 1 || STEP_DWELL > 255) begin : g_bad_dwell
      $error("STEP_DWELL out of range 1..255");
   end
   if (KICK_CYCLES < 1 || KICK_CYCLES > 255) begin : g_bad_kick
      $error("KICK_CYCLES out of range 1..255");
   end

   localparam logic [7:0] DWELL_RELOAD = 8'(STEP_DWELL - 1);
`ifdef FAN_KICKSTART_EN
   localparam logic [7:0] KICK_RELOAD  = 8'(KICK_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HOLD      = 3'd1,
      RAMP_UP   = 3'd2,
      RAMP_DOWN = 3'd3,
`ifdef FAN_KICKSTART_EN
      KICK      = 3'd5,
`endif
      FAULT     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] target_q, target_d;
   logic       fault_q, fault_d;
   logic [2:0] level_q, level_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] pwm_cnt_q, pwm_cnt_d;
   logic       pwm_q, pwm_d;
   logic       settled_q, settled_d;
   logic       ramping_q, ramping_d;

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      cnt_d     = cnt_q;
      target_d  = fault ? 3'd7 : (enable ? fan_mode : 3'd0);
      // Remembers that the current target_q came from a fault, not from fan_mode=7.
      fault_d   = fault;
      pwm_cnt_d = (pwm_cnt_q == 3'd6) ? 3'd0 : pwm_cnt_q + 3'd1;
      pwm_d     = (pwm_cnt_q < level_q);

      if (fault_q) begin
         state_d = FAULT;
         level_d = 3'd7;
         cnt_d   = 8'd0;
      end else begin
         unique case (state_q)
            IDLE, HOLD, FAULT: begin
               if (target_q > level_q) begin
`ifdef FAN_KICKSTART_EN
                  if (state_q == IDLE) begin
                     state_d = KICK;
                     level_d = 3'd7;
                     cnt_d   = KICK_RELOAD;
                  end else begin
                     state_d = RAMP_UP;
                     cnt_d   = DWELL_RELOAD;
                  end
`else
                  state_d = RAMP_UP;
                  cnt_d   = DWELL_RELOAD;
`endif
               end else if (target_q < level_q) begin
                  state_d = RAMP_DOWN;
                  cnt_d   = DWELL_RELOAD;
               end else begin
                  state_d = (level_q == 3'd0) ? IDLE : HOLD;
               end
            end
            RAMP_UP: begin
               if (target_q == level_q) begin
                  state_d = HOLD;
               end else if (target_q < level_q) begin
                  state_d = RAMP_DOWN;
                  cnt_d   = DWELL_RELOAD;
               end else if (cnt_q == 8'd0) begin
                  level_d = level_q + 3'd1;
                  cnt_d   = DWELL_RELOAD;
                  if (level_q + 3'd1 == target_q) state_d = HOLD;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            RAMP_DOWN: begin
               if (target_q == level_q) begin
                  state_d = (level_q == 3'd0) ? IDLE : HOLD;
               end else if (target_q > level_q) begin
                  state_d = RAMP_UP;
                  cnt_d   = DWELL_RELOAD;
               end else if (cnt_q == 8'd0) begin
                  level_d = level_q - 3'd1;
                  cnt_d   = DWELL_RELOAD;
                  if (level_q - 3'd1 == target_q)
                     state_d = (level_q == 3'd1) ? IDLE : HOLD;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
`ifdef FAN_KICKSTART_EN
            KICK: begin
               if (target_q == 3'd0) begin
                  // Ride disabled mid-kick: wind down from full speed.
                  state_d = RAMP_DOWN;
                  cnt_d   = DWELL_RELOAD;
               end else if (cnt_q == 8'd0) begin
                  level_d = 3'd1;
                  cnt_d   = DWELL_RELOAD;
                  state_d = (target_q == 3'd1) ? HOLD : RAMP_UP;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
`endif
            default: begin
               state_d = IDLE;
               level_d = 3'd0;
               cnt_d   = 8'd0;
            end
         endcase
      end

      settled_d = (state_d == IDLE) || (state_d == HOLD);
`ifdef FAN_KICKSTART_EN
      ramping_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN) || (state_d == KICK);
`else
      ramping_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         target_q  <= 3'd0;
         fault_q   <= 1'b0;
         level_q   <= 3'd0;
         cnt_q     <= 8'd0;
         pwm_cnt_q <= 3'd0;
         pwm_q     <= 1'b0;
         settled_q <= 1'b1;
         ramping_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         fault_q   <= fault_d;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= pwm_d;
         settled_q <= settled_d;
         ramping_q <= ramping_d;
      end
   end

   assign fan_level = level_q;
   assign pwm_out   = pwm_q;
   assign settled   = settled_q;
   assign ramping   = ramping_q;

endmodule
